gaussian_stream_arbiter: RTL and testbench
==========================================

# gaussian_stream_arbiter

Round-robin burst arbiter that shares one 256-bit AXI-Stream Gaussian sample source among NUM_REQ consumers. Each consumer raises a request with a burst length. The arbiter grants the stream to one consumer at a time, passes exactly that many beats through with TLAST on the final beat, then releases the source. It sits between the Gaussian stream generator's master port and the downstream sample consumers (DMA channels, noise injectors).

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 256, stream data width
- LEN_W, 8, burst length field width; a burst is req_len+1 beats
- axis_aclk  in  1  clock, all logic on rising edge
- axis_areset  in  1  asynchronous, active-high reset
- s_axis_tdata  in  DATA_W  sample data from the Gaussian source
- s_axis_tvalid  in  1  source data valid
- s_axis_tready  out  1  arbiter accepts a source beat
- req  in  NUM_REQ  per-requester burst request, level
- req_len  in  NUM_REQ*LEN_W  per-requester length minus one; field i at [i*LEN_W +: LEN_W]
- grant  out  NUM_REQ  one-hot current owner; all zero when idle
- m_axis_tdata  out  DATA_W  broadcast copy of s_axis_tdata
- m_axis_tvalid  out  NUM_REQ  per-requester valid
- m_axis_tready  in  NUM_REQ  per-requester ready
- m_axis_tlast  out  1  final beat of the current burst
- done  out  NUM_REQ  one-cycle pulse when requester i's final beat transfers

## Operation
- States: IDLE, BURST.
- IDLE: if any req bit is set, select the first set bit searching upward from rr_ptr with wrap. At the clock edge:
  - register grant for the selected bit;
  - load beat_cnt with that requester's req_len;
  - enter BURST.
  - If no req bit is set, stay in IDLE.
- BURST, with g the granted index:
  - s_axis_tready = m_axis_tready[g]
  - m_axis_tvalid[g] = s_axis_tvalid; all other m_axis_tvalid bits are 0
  - m_axis_tdata = s_axis_tdata, combinational pass-through
  - m_axis_tlast = (beat_cnt == 0)
- A beat transfers when s_axis_tvalid and m_axis_tready[g] are both high. On a transfer:
  - if beat_cnt != 0, decrement beat_cnt;
  - if beat_cnt == 0, this is the final beat: pulse done[g] for the following cycle, set rr_ptr = (g+1) mod NUM_REQ, clear grant, and return to IDLE.
- req_len is sampled only at grant. Later changes to req_len, or dropping req, do not affect a running burst. The burst always completes.
- A requester that still has req high after its done pulse competes again in IDLE, behind the others in round-robin order.
- In IDLE, s_axis_tready is 0 and every m_axis_tvalid bit is 0.
- beat_cnt is LEN_W bits and never wraps: decrement happens only when it is nonzero.

## Timing
- Reset values (asynchronous): state IDLE, rr_ptr 0, beat_cnt 0, grant 0, done 0.
- Because every output is derived from state, all of these are 0 during reset and in the cycle after it: s_axis_tready, m_axis_tvalid, m_axis_tlast, grant, done.
- Grant latency: req sampled high at edge t in IDLE gives grant high after edge t. The first beat can transfer in the cycle between edges t and t+1.
- Data path: zero-cycle latency; tdata, tvalid and tready are combinational through the arbiter in BURST.
- Throughput: one beat per cycle under full handshake. A burst of L+1 beats occupies L+1 cycles of BURST, followed by at least one IDLE cycle before the next grant.
- done[g] is registered: it is high in the cycle after the final-beat edge, concurrent with the IDLE cycle.
- Stalls: tvalid low or m_axis_tready[g] low holds beat_cnt, grant and tlast unchanged. No beat is lost or duplicated.
- Reset asserted mid-burst: immediate return to IDLE, grant cleared, and no done pulse. The consumer sees a truncated burst with no TLAST; this is acceptable.
- Simultaneous requests: resolved purely by rr_ptr order. Ties never stall.

## Test plan
- Single burst: req[0]=1 with req_len[0]=3, source and sink always ready.
  - grant=0001 one cycle after req;
  - exactly 4 beats on m_axis_tvalid[0] with tdata equal to the source data;
  - tlast on beat 4 only;
  - done[0] pulses once, then grant returns to 0.
- Round robin: after reset, req=1010 held with all lengths 0.
  - Grants alternate 0010, 1000, 0010, ...
  - Each grant lasts one beat and is separated by one idle cycle.
- Backpressure: req[2] with length 7; drop m_axis_tready[2] for 5 cycles mid-burst.
  - s_axis_tready follows m_axis_tready[2];
  - beat_cnt holds during the stall;
  - exactly 8 beats total with tlast on the 8th.
- Source gaps: s_axis_tvalid toggles with a random pattern during a 16-beat burst (req_len=15).
  - Exactly 16 transfers, tlast on the 16th;
  - no m_axis_tvalid on ungranted ports.
- Maximum length and late changes: req_len=255.
  - 256 beats;
  - changing req_len and dropping req mid-burst have no effect;
  - no wrap past 0.
- Reset mid-burst: assert axis_areset at beat 3 of an 8-beat burst.
  - All outputs go to 0 asynchronously and no done pulse is produced;
  - after release, the next grant goes to requester 0.

Source files
------------

// File: rtl/gaussian_stream_arbiter_if.sv
// Bus bundle for the Gaussian stream arbiter: the source-side AXI-Stream slave,
// the per-requester burst request lines and the broadcast consumer stream.
// The arbiter connects through the slave modport; the environment uses master.
interface gaussian_stream_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 256,
   parameter int unsigned LEN_W   = 8
);
   // Source side (Gaussian generator to arbiter)
   logic [DATA_W-1:0]        s_axis_tdata;
   logic                     s_axis_tvalid;
   logic                     s_axis_tready;
   // Burst requests
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*LEN_W-1:0] req_len;
   logic [NUM_REQ-1:0]       grant;
   logic [NUM_REQ-1:0]       done;
   // Consumer side (arbiter to requesters)
   logic [DATA_W-1:0]        m_axis_tdata;
   logic [NUM_REQ-1:0]       m_axis_tvalid;
   logic [NUM_REQ-1:0]       m_axis_tready;
   logic                     m_axis_tlast;

   modport slave (
      input  s_axis_tdata,
      input  s_axis_tvalid,
      output s_axis_tready,
      input  req,
      input  req_len,
      output grant,
      output done,
      output m_axis_tdata,
      output m_axis_tvalid,
      input  m_axis_tready,
      output m_axis_tlast
   );

   modport master (
      output s_axis_tdata,
      output s_axis_tvalid,
      input  s_axis_tready,
      output req,
      output req_len,
      input  grant,
      input  done,
      input  m_axis_tdata,
      input  m_axis_tvalid,
      output m_axis_tready,
      input  m_axis_tlast
   );
endinterface

// File: rtl/gaussian_stream_arbiter.sv
// Round-robin burst arbiter sharing one AXI-Stream Gaussian sample source
// among NUM_REQ consumers. A granted requester receives req_len+1 beats with
// TLAST on the final one; the source is then released and rr_ptr advances.
module gaussian_stream_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 256,
   parameter int unsigned LEN_W   = 8
) (
   input  logic                       axis_aclk,
   input  logic                       axis_areset,
   gaussian_stream_arbiter_if.slave   bus
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   typedef enum logic {StIdle, StBurst} state_t;

   state_t             state_q;
   logic [IDX_W-1:0]   rr_ptr_q;
   logic [IDX_W-1:0]   g_idx_q;
   logic [LEN_W-1:0]   beat_cnt_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [NUM_REQ-1:0] done_q;

   logic               sel_found;
   logic [IDX_W-1:0]   sel_idx;
   logic [IDX_W-1:0]   cand_idx;
   int unsigned        cand;
   logic [LEN_W-1:0]   sel_len;
   logic [IDX_W-1:0]   rr_next;
   logic               busy;
   logic               xfer;

   // Pick the first pending request at or above rr_ptr, wrapping around.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(rr_ptr_q) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = cand[IDX_W-1:0];
         if (!sel_found && bus.req[cand_idx]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx;
         end
      end
   end

   // Length and pointer helpers for the FSM.
   always_comb begin
      sel_len = bus.req_len[sel_idx*LEN_W +: LEN_W];
      if (g_idx_q == IDX_W'(NUM_REQ - 1)) begin
         rr_next = '0;
      end else begin
         rr_next = g_idx_q + 1'b1;
      end
   end

   // Datapath is purely combinational while a burst is running.
   always_comb begin
      busy              = (state_q == StBurst);
      xfer              = busy && bus.s_axis_tvalid && bus.m_axis_tready[g_idx_q];
      bus.s_axis_tready = busy && bus.m_axis_tready[g_idx_q];
      bus.m_axis_tvalid = (busy && bus.s_axis_tvalid) ? grant_q : '0;
      bus.m_axis_tdata  = bus.s_axis_tdata;
      bus.m_axis_tlast  = busy && (beat_cnt_q == '0);
      bus.grant         = grant_q;
      bus.done          = done_q;
   end

   // Burst FSM: grant on request, count beats down, release after the last.
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         g_idx_q    <= '0;
         beat_cnt_q <= '0;
         grant_q    <= '0;
         done_q     <= '0;
      end else begin
         done_q <= '0;
         case (state_q)
            StIdle: begin
               if (sel_found) begin
                  grant_q    <= NUM_REQ'(1) << sel_idx;
                  g_idx_q    <= sel_idx;
                  beat_cnt_q <= sel_len;
                  state_q    <= StBurst;
               end
            end
            StBurst: begin
               if (xfer) begin
                  if (beat_cnt_q != '0) begin
                     beat_cnt_q <= beat_cnt_q - 1'b1;
                  end else begin
                     done_q   <= NUM_REQ'(1) << g_idx_q;
                     rr_ptr_q <= rr_next;
                     grant_q  <= '0;
                     state_q  <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_gaussian_stream_arbiter.sv
// Directed bench for gaussian_stream_arbiter. The source produces a known
// data sequence advanced on each handshake; expected beats are queued when a
// burst is requested and popped as the consumer side transfers them.
module tb_gaussian_stream_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned DW = 256;
   localparam int unsigned LW = 8;

   typedef struct {
      int          port;
      int unsigned idx;
      bit          last;
   } beat_t;

   logic clk;
   logic areset;

   gaussian_stream_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .LEN_W(LW)) bus ();

   gaussian_stream_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .LEN_W(LW)) dut (
      .axis_aclk   (clk),
      .axis_areset (areset),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   beat_t       q[$];
   int unsigned exp_idx = 0;
   int unsigned src_idx = 0;
   logic [NR-1:0] exp_done = '0;
   logic [NR-1:0] snk_rdy = '1;
   bit          rand_vld = 1'b0;
   int          n;

   function automatic logic [DW-1:0] gen(input int unsigned k);
      logic [DW-1:0] v;
      for (int j = 0; j < 8; j++) begin
         v[j*32 +: 32] = (k * 8 + j) * 32'h9E3779B9 + 32'h7F4A7C15;
      end
      return v;
   endfunction

   function automatic logic [NR-1:0] oh(input int p);
      logic [NR-1:0] v;
      v = '0;
      v[p] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_burst(input int p, input int len);
      for (int j = 0; j <= len; j++) begin
         q.push_back('{port: p, idx: exp_idx, last: (j == len)});
         exp_idx++;
      end
   endtask

   task automatic drive();
      bus.s_axis_tvalid = rand_vld ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_axis_tdata  = gen(src_idx);
      bus.m_axis_tready = snk_rdy;
      if (q.size() == 0) bus.req = '0;
   endtask

   task automatic set_len(input int p, input int len);
      bus.req_len[p*LW +: LW] = LW'(len);
   endtask

   // One clock: check at the falling edge, then drive just after the rising edge.
   task automatic cyc();
      logic [NR-1:0] nxt_done;
      logic [NR-1:0] xfer;
      bit            src_adv;
      int            p;
      @(negedge clk);
      nxt_done = '0;
      chk("done", DW'(bus.done), DW'(exp_done));
      if (bus.grant != '0) begin
         if (q.size() == 0) begin
            chk("grant_unexpected", DW'(bus.grant), DW'(0));
         end else begin
            p = q[0].port;
            chk("grant", DW'(bus.grant), DW'(oh(p)));
            chk("s_tready", DW'(bus.s_axis_tready), DW'(snk_rdy[p]));
            chk("m_tvalid", DW'(bus.m_axis_tvalid), DW'(bus.s_axis_tvalid ? oh(p) : '0));
            chk("tlast", DW'(bus.m_axis_tlast), DW'(q[0].last));
            chk("tdata_pass", bus.m_axis_tdata, bus.s_axis_tdata);
         end
      end else begin
         chk("idle_s_tready", DW'(bus.s_axis_tready), DW'(0));
         chk("idle_m_tvalid", DW'(bus.m_axis_tvalid), DW'(0));
         chk("idle_tlast", DW'(bus.m_axis_tlast), DW'(0));
      end
      xfer = bus.m_axis_tvalid & bus.m_axis_tready;
      if (xfer != '0) begin
         if (q.size() == 0) begin
            chk("extra_beat", DW'(xfer), DW'(0));
         end else begin
            chk("beat_data", bus.m_axis_tdata, gen(q[0].idx));
            if (q[0].last) nxt_done = oh(q[0].port);
            void'(q.pop_front());
         end
      end
      src_adv  = bus.s_axis_tvalid && bus.s_axis_tready;
      exp_done = nxt_done;
      @(posedge clk);
      #1;
      if (src_adv) src_idx++;
      drive();
   endtask

   task automatic drain(input int budget, output int cnt);
      cnt = 0;
      while (q.size() != 0 && cnt < budget) begin
         cyc();
         cnt++;
      end
      chk("drain_timeout", DW'(q.size()), DW'(0));
      cyc();
   endtask

   initial begin
      areset            = 1'b1;
      bus.req           = '0;
      bus.req_len       = '0;
      bus.m_axis_tready = '1;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = gen(0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_grant", DW'(bus.grant), DW'(0));
      chk("rst_s_tready", DW'(bus.s_axis_tready), DW'(0));
      chk("rst_m_tvalid", DW'(bus.m_axis_tvalid), DW'(0));
      chk("rst_tlast", DW'(bus.m_axis_tlast), DW'(0));
      chk("rst_done", DW'(bus.done), DW'(0));
      areset = 1'b0;
      drive();
      cyc();

      // Single burst of 4 beats to requester 0.
      set_len(0, 3);
      bus.req = 4'b0001;
      push_burst(0, 3);
      cyc();
      chk("single_grant_latency", DW'(bus.grant), DW'(4'b0001));
      drain(20, n);
      chk("single_cycles", DW'(n), DW'(4));
      chk("single_grant_released", DW'(bus.grant), DW'(0));

      // Round robin between requesters 1 and 3, single-beat bursts.
      set_len(1, 0);
      set_len(3, 0);
      bus.req = 4'b1010;
      push_burst(1, 0);
      push_burst(3, 0);
      push_burst(1, 0);
      push_burst(3, 0);
      drain(40, n);
      chk("rr_cycles", DW'(n), DW'(8));

      // Backpressure on requester 2, 8-beat burst, 5-cycle sink stall.
      set_len(2, 7);
      bus.req = 4'b0100;
      push_burst(2, 7);
      repeat (4) cyc();
      snk_rdy[2] = 1'b0;
      bus.m_axis_tready = snk_rdy;
      repeat (5) cyc();
      chk("bp_remaining", DW'(q.size()), DW'(5));
      snk_rdy[2] = 1'b1;
      bus.m_axis_tready = snk_rdy;
      drain(20, n);
      chk("bp_drain_cycles", DW'(n), DW'(5));

      // Reset during beat 3 of an 8-beat burst to requester 3.
      set_len(3, 7);
      bus.req = 4'b1000;
      push_burst(3, 7);
      for (int k = 0; k < 20 && q.size() > 6; k++) cyc();
      chk("mid_beats_before_reset", DW'(q.size()), DW'(6));
      #1;
      areset = 1'b1;
      #1;
      chk("mid_rst_grant", DW'(bus.grant), DW'(0));
      chk("mid_rst_s_tready", DW'(bus.s_axis_tready), DW'(0));
      chk("mid_rst_m_tvalid", DW'(bus.m_axis_tvalid), DW'(0));
      chk("mid_rst_tlast", DW'(bus.m_axis_tlast), DW'(0));
      exp_idx = exp_idx - q.size();
      q.delete();
      bus.req = '0;
      cyc();
      areset = 1'b0;
      cyc();
      set_len(0, 0);
      set_len(1, 0);
      set_len(2, 0);
      set_len(3, 0);
      bus.req = 4'b1111;
      push_burst(0, 0);
      cyc();
      chk("post_rst_grant", DW'(bus.grant), DW'(4'b0001));
      drain(10, n);

      // 16-beat burst to requester 1 with random source gaps.
      set_len(1, 15);
      bus.req = 4'b0010;
      push_burst(1, 15);
      rand_vld = 1'b1;
      drain(200, n);
      rand_vld = 1'b0;
      drive();

      // 256-beat burst to requester 3; req_len and req change mid-burst.
      set_len(3, 255);
      bus.req = 4'b1000;
      push_burst(3, 255);
      repeat (10) cyc();
      set_len(3, 5);
      bus.req = '0;
      drain(600, n);
      chk("max_cycles", DW'(n + 10), DW'(257));
      cyc();
      chk("max_grant_released", DW'(bus.grant), DW'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
